// File: rtl/my_mul_acc.sv
// Streaming accumulator for my_mul products: sums ACC_LEN signed beats with a
// sticky overflow flag. Define MY_MUL_ACC_SAT_EN for saturating adds (default wraps).
module my_mul_acc #(
    parameter int BITWIDTH = 32,
    parameter int ACC_LEN  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BITWIDTH-1:0] in_data,
    input  logic                       in_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [BITWIDTH-1:0] out_data,
    output logic                       out_ovf,
    output logic                       out_cnt_err
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam int MSB   = BITWIDTH - 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

    state_t                     state_reg, state_next;
    logic signed [BITWIDTH-1:0] acc_reg, acc_next;
    logic signed [BITWIDTH-1:0] sum_raw, sum_add;
    logic        [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                       sticky_reg, sticky_next;
    logic        [BITWIDTH-1:0] out_data_reg, out_data_next;
    logic                       out_ovf_reg, out_ovf_next;
    logic                       cnt_err_reg, cnt_err_next;
    logic                       add_ovf;
    logic                       beat_sticky;

    // Signed overflow: operands agree in sign but the sum does not.
    assign sum_raw     = acc_reg + in_data;
    assign add_ovf     = (acc_reg[MSB] == in_data[MSB]) && (sum_raw[MSB] != acc_reg[MSB]);
    assign beat_sticky = sticky_reg | in_ovf | add_ovf;

`ifdef MY_MUL_ACC_SAT_EN
    always_comb begin
        sum_add = sum_raw;
        if (add_ovf) begin
            sum_add = acc_reg[MSB] ? {1'b1, {(BITWIDTH-1){1'b0}}}
                                   : {1'b0, {(BITWIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_add = sum_raw;
`endif

    assign in_ready    = (state_reg == ACCUM);
    assign out_valid   = (state_reg == HOLD);
    assign out_data    = out_data_reg;
    assign out_ovf     = out_ovf_reg;
    assign out_cnt_err = cnt_err_reg;

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        sticky_next   = sticky_reg;
        out_data_next = out_data_reg;
        out_ovf_next  = out_ovf_reg;
        cnt_err_next  = 1'b0;

        if (clear) begin
            // Abort wins over both handshakes; only a partial group is an error.
            state_next   = ACCUM;
            acc_next     = '0;
            cnt_next     = '0;
            sticky_next  = 1'b0;
            cnt_err_next = (cnt_reg != '0);
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt_reg == LAST_CNT) begin
                            out_data_next = sum_add;
                            out_ovf_next  = beat_sticky;
                            acc_next      = '0;
                            cnt_next      = '0;
                            sticky_next   = 1'b0;
                            state_next    = HOLD;
                        end else begin
                            acc_next    = sum_add;
                            cnt_next    = cnt_reg + CNT_W'(1);
                            sticky_next = beat_sticky;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = ACCUM;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ACCUM;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            sticky_reg   <= 1'b0;
            out_data_reg <= '0;
            out_ovf_reg  <= 1'b0;
            cnt_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            sticky_reg   <= sticky_next;
            out_data_reg <= out_data_next;
            out_ovf_reg  <= out_ovf_next;
            cnt_err_reg  <= cnt_err_next;
        end
    end
endmodule

// File: tb/tb_my_mul_acc.sv
// Bench for my_mul_acc: directed plan plus random traffic against a group-level
// model (beats queued, result summed with plain integer arithmetic).
module tb_my_mul_acc;
    localparam int LEN = 8;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint MOD  = 64'sd4294967296;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ovf = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_ovf, out_cnt_err;
    logic [31:0] out_data;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    bit          m_hold = 1'b0;
    bit          m_err = 1'b0;
    bit          m_out_ovf = 1'b0;
    logic [31:0] m_out_data = '0;
    logic [31:0] m_beats[$];
    bit          m_flags[$];

    my_mul_acc #(.BITWIDTH(32), .ACC_LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ovf(in_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_cnt_err(out_cnt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sum a complete group with 64-bit arithmetic, folding back into 32 bits per beat.
    function automatic void group_result(output logic [31:0] res, output bit ovf);
        longint s;
        s = 0;
        ovf = 1'b0;
        foreach (m_beats[i]) begin
            s = s + longint'($signed(m_beats[i]));
            ovf = ovf | m_flags[i];
            if (s > SMAX || s < SMIN) begin
                ovf = 1'b1;
`ifdef MY_MUL_ACC_SAT_EN
                s = (s > SMAX) ? SMAX : SMIN;
`else
                s = (s > SMAX) ? s - MOD : s + MOD;
`endif
            end
        end
        res = s[31:0];
    endfunction

    task automatic model_reset();
        m_hold = 1'b0;
        m_err = 1'b0;
        m_out_ovf = 1'b0;
        m_out_data = '0;
        m_beats.delete();
        m_flags.delete();
    endtask

    task automatic model_step();
        if (clear) begin
            m_err = (m_beats.size() != 0);
            m_beats.delete();
            m_flags.delete();
            m_hold = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_hold) begin
                if (out_ready) m_hold = 1'b0;
            end else if (in_valid) begin
                m_beats.push_back(in_data);
                m_flags.push_back(in_ovf);
                if (m_beats.size() == LEN) begin
                    group_result(m_out_data, m_out_ovf);
                    m_beats.delete();
                    m_flags.delete();
                    m_hold = 1'b1;
                end
            end
        end
    endtask

    // Inputs change 1 time unit after the edge; the model advances on the edge.
    task automatic cycle(bit v, logic [31:0] d, bit o, bit r, bit c);
        in_valid = v; in_data = d; in_ovf = o; out_ready = r; clear = c;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic expect_res(string name, logic [31:0] d, bit o);
        chk({name, "_model"}, m_out_data, d);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_ovf"}, out_ovf, o);
        $display("result %s: data=%h ovf=%0b", name, out_data, out_ovf);
    endtask

    task automatic async_reset(string name);
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; in_ovf = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk({name, "_valid"}, out_valid, 1'b0);
        chk({name, "_ready"}, in_ready, 1'b1);
        chk({name, "_data"}, out_data, 32'h0);
        chk({name, "_ovf"}, out_ovf, 1'b0);
        chk({name, "_err"}, out_cnt_err, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, !m_hold);
            chk("out_valid", out_valid, m_hold);
            chk("cnt_err", out_cnt_err, m_err);
            if (m_hold) begin
                chk("out_data", out_data, m_out_data);
                chk("out_ovf", out_ovf, m_out_ovf);
            end
            if (!rst_n) chk("rst_data", out_data, 32'h0);
        end
    end

    initial begin
        logic [31:0] d;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        chk("init_ready", in_ready, 1'b1);
        chk("init_data", out_data, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Eight beats of 3.
        repeat (LEN) cycle(1, 32'd3, 0, 1, 0);
        expect_res("sum24", 32'd24, 1'b0);
        cycle(0, 0, 0, 1, 0);
        chk("sum24_ready_back", in_ready, 1'b1);

        // Positive overflow on the second beat.
        cycle(1, 32'h7FFF_FFFF, 0, 1, 0);
        cycle(1, 32'd1, 0, 1, 0);
        repeat (LEN - 2) cycle(1, 32'd0, 0, 1, 0);
`ifdef MY_MUL_ACC_SAT_EN
        expect_res("posovf", 32'h7FFF_FFFF, 1'b1);
`else
        expect_res("posovf", 32'h8000_0000, 1'b1);
`endif
        cycle(0, 0, 0, 1, 0);

        // Product overflow flag on the 4th beat, then sticky must clear.
        for (int i = 0; i < LEN; i++) cycle(1, 32'hFFFF_FFFF, (i == 3), 1, 0);
        expect_res("neg8", 32'hFFFF_FFF8, 1'b1);
        cycle(0, 0, 0, 1, 0);
        repeat (LEN) cycle(1, 32'd1, 0, 1, 0);
        expect_res("ones", 32'd8, 1'b0);
        cycle(0, 0, 0, 1, 0);

        // Back-pressure: result held, nothing accepted.
        repeat (LEN) cycle(1, 32'd5, 0, 1, 0);
        expect_res("hold", 32'd40, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 32'd7, 0, 0, 0);
            chk("hold_stable", out_data, 32'd40);
            chk("hold_ready", in_ready, 1'b0);
        end
        cycle(1, 32'd7, 0, 1, 0);
        chk("hold_release", in_ready, 1'b1);
        cycle(1, 32'd7, 0, 1, 0);
        chk("hold_first_beat", m_beats.size(), 32'd1);

        // Abort a 3-beat partial group; the beat under clear is dropped.
        repeat (2) cycle(1, 32'd7, 0, 1, 0);
        cycle(1, 32'd9, 0, 1, 1);
        chk("clear_err_pulse", out_cnt_err, 1'b1);
        repeat (LEN) cycle(1, 32'd2, 0, 1, 0);
        chk("clear_err_gone", out_cnt_err, 1'b0);
        expect_res("after_clear", 32'd16, 1'b0);
        cycle(0, 0, 0, 1, 0);

        // Asynchronous reset mid-group and while holding a result.
        repeat (5) cycle(1, 32'd4, 0, 1, 0);
        async_reset("rst_mid");
        repeat (LEN) cycle(1, 32'd6, 0, 1, 0);
        expect_res("post_rst", 32'd48, 1'b0);
        async_reset("rst_hold");
        repeat (LEN) cycle(1, 32'd1, 0, 1, 0);
        expect_res("post_rst2", 32'd8, 1'b0);
        cycle(0, 0, 0, 1, 0);

        // Random traffic with extremes, flags, back-pressure and aborts.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0: d = 32'h7FFF_FFFF;
                1: d = 32'h8000_0000;
                2: d = 32'h4000_0000;
                default: d = $urandom;
            endcase
            cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end
        cycle(0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/my_mul_acc.md
Name: my_mul_acc

Overview:
- Downstream consumer of the combinational multiplier `my_mul`.
- Accepts a stream of signed products plus their overflow flags over a valid/ready handshake.
- Sums each group of ACC_LEN products into one signed total with a sticky overflow flag.
- Presents the total on a valid/ready output port for the next stage (dot-product / MAC datapath).

Parameters:
- BITWIDTH, 32, width of product input, accumulator and result (two's complement).
- ACC_LEN, 8, products summed per result; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous abort: discards the partial sum and any held result.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a product.
- in_data  input  BITWIDTH  signed product (`my_mul` dout).
- in_ovf  input  1  product overflow (`my_mul` overflow).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  BITWIDTH  signed accumulated sum.
- out_ovf  output  1  sticky overflow for this result.
- out_cnt_err  output  1  pulses 1 cycle when clear aborts a partial group.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst_n low, asynchronously: state=ACCUM, acc=0, cnt=0, ovf_sticky=0, out_valid=0, out_data=0, out_ovf=0, out_cnt_err=0, in_ready=1 (combinational from state).
  - Reset mid-group discards all partial data.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid&in_ready at the rising edge.
  - On each accept:
    - acc <= add(acc, in_data).
    - ovf_sticky <= ovf_sticky | in_ovf | add_ovf.
    - cnt <= cnt+1.
  - The accept with cnt==ACC_LEN-1:
    - out_data <= add(acc, in_data); out_ovf <= final sticky value (including this beat).
    - out_valid <= 1; acc, cnt, ovf_sticky <= 0; go to HOLD.
  - Latency: out_valid rises on the edge that accepts the ACC_LEN-th beat, so it is visible the following cycle.
- HOLD:
  - in_ready=0; out_valid=1; out_data/out_ovf stable.
  - out_valid&out_ready at an edge: out_valid <= 0, go to ACCUM.
  - No bypass: a new beat is earliest accepted the cycle after the handshake. Max throughput is ACC_LEN+1 cycles per result.
- Arithmetic:
  - Signed BITWIDTH add.
  - add_ovf = operands same sign and result sign differs.
  - add() behaviour on add_ovf is set by the optional feature.
  - in_ovf does not alter the data path; it only sets the sticky flag.
- clear (synchronous, priority over all handshakes in the same cycle):
  - acc, cnt, ovf_sticky <= 0; out_valid <= 0; state <= ACCUM.
  - out_cnt_err <= 1 for one cycle iff cnt!=0 at that edge; otherwise 0.
  - A beat presented with clear is dropped.
- Boundaries:
  - in_valid held high through HOLD: nothing accepted; the beat is taken on the first ACCUM cycle.
  - out_ready high while out_valid low: ignored.

Optional Feature:
- Macro: MY_MUL_ACC_SAT_EN.
- Defined: add() saturates on add_ovf, to 2^(BITWIDTH-1)-1 on positive overflow and -2^(BITWIDTH-1) on negative. Accumulation continues from the saturated value.
- Undefined: add() wraps modulo 2^BITWIDTH.
- add_ovf sets ovf_sticky in both builds.

Test Plan:
- Reset, then ACC_LEN=8 beats of in_data=3, in_ovf=0, in_valid held high, out_ready=1 -> out_valid asserted 1 cycle after the 8th accept; out_data=24, out_ovf=0; in_ready low exactly 1 cycle.
- Beats 0x7FFFFFFF, 1, then 6x0 -> SAT build: out_data=0x7FFFFFFF, out_ovf=1. Wrap build: out_data=0x80000000, out_ovf=1.
- 8 beats of -1 (0xFFFFFFFF), the 4th with in_ovf=1 -> out_data=0xFFFFFFF8, out_ovf=1; next group of 8x1 -> out_data=8, out_ovf=0 (sticky cleared).
- out_ready=0 for 5 cycles after a result, in_valid=1 -> out_data stable, in_ready=0, no beat accepted; on out_ready=1 handshake, the next accept occurs the following cycle.
- 3 beats accepted, then clear pulse with in_valid=1 -> out_cnt_err=1 for one cycle; that beat dropped; the next 8 beats of 2 -> out_data=16.
- rst_n low asynchronously mid-group (after 5 beats) and during HOLD -> all outputs 0 immediately, in_ready=1; the next full group sums correctly from 0.
